// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit for the 5-stage RISC-V pipeline.
// Drives a ready/valid data bus, steers store bytes to lanes, extracts and
// extends load data, and stalls upstream while an access is outstanding.
// Optional build macro: LSU_TIMEOUT_EN adds a response timeout that ends the
// access with no write-back and flags it on misalign_out.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  flush,
  input  logic                  regwrite_in,
  input  logic [1:0]            mem_to_reg_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [31:0]           alu_result_in,
  input  logic [31:0]           rs2_data_in,
  input  logic [31:0]           pc_plus_4_in,
  input  logic [4:0]            rd_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata,
  output logic                  stall_out,
  output logic                  misalign_out,
  output logic                  regwrite_out,
  output logic [1:0]            mem_to_reg_out,
  output logic [31:0]           mem_read_data_out,
  output logic [31:0]           alu_result_out,
  output logic [31:0]           pc_plus_4_out,
  output logic [4:0]            rd_out
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  // Instruction snapshot taken when an access launches; EX/MEM may change
  // underneath us, so everything driven later comes from here.
  typedef struct packed {
    logic        regwrite;
    logic [1:0]  mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus_4;
    logic [4:0]  rd;
    logic [3:0]  be;
    logic [31:0] wdata;
  } lsu_req_t;

  state_t         state_q, state_d;
  lsu_req_t       req_q, req_new;
  logic [31:0]    rdata_q, rdata_ext, shifted;
  logic           flush_seen_q;
  logic           mem_op, misaligned, load_cap;
  logic [3:0]     lane_be;
  logic [3:0][7:0] lane_wdata;
  logic           tmo_hit, tmo_seen_q;

  // Live memory op: a flushed instruction never reaches the bus.
  assign mem_op = valid_in & ~flush & (mem_read_in | mem_write_in);

  // Byte lane steering: B replicates the low byte, H the low half, W is direct.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign lane_wdata[i] = (funct3_in[1:0] == 2'b00) ? rs2_data_in[7:0] :
                           (funct3_in[1:0] == 2'b01) ? rs2_data_in[8*(i%2) +: 8] :
                                                       rs2_data_in[8*i +: 8];
    assign lane_be[i]    = (funct3_in[1:0] == 2'b00) ? (alu_result_in[1:0] == LANE) :
                           (funct3_in[1:0] == 2'b01) ? (alu_result_in[1] == LANE[1]) :
                                                       1'b1;
  end

  // Halves need even addresses, words need 4-byte alignment.
  always_comb begin
    case (funct3_in[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result_in[0];
      default: misaligned = |alu_result_in[1:0];
    endcase
  end

  assign req_new = '{regwrite:   regwrite_in,
                     mem_to_reg: mem_to_reg_in,
                     mem_read:   mem_read_in & ~mem_write_in,
                     mem_write:  mem_write_in,
                     funct3:     funct3_in,
                     alu_result: alu_result_in,
                     pc_plus_4:  pc_plus_4_in,
                     rd:         rd_in,
                     be:         lane_be,
                     wdata:      lane_wdata};

  // Load extract: shift the addressed byte/half down, then sign/zero extend.
  always_comb begin
    shifted = dmem_rdata >> {req_q.alu_result[1:0], 3'b000};
    case (req_q.funct3)
      3'b000:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  rdata_ext = {24'h0, shifted[7:0]};
      3'b101:  rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          tmo_fire;

  assign tmo_hit  = ((state_q == REQ) || (state_q == RESP)) &&
                    (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  // Completion in the same cycle wins over the timeout.
  assign tmo_fire = tmo_hit & ((state_q == REQ) ? ~dmem_ready : ~dmem_rvalid);

  // Cycles spent waiting on the bus; zero outside REQ/RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     tmo_cnt_q <= '0;
    else if ((state_q == REQ) || (state_q == RESP)) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else                                           tmo_cnt_q <= '0;
  end

  // Remember a timed-out access so DONE suppresses write-back and flags it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tmo_seen_q <= 1'b0;
    else if (tmo_fire)        tmo_seen_q <= 1'b1;
    else if (state_q == DONE) tmo_seen_q <= 1'b0;
  end
`else
  assign tmo_hit    = 1'b0;
  assign tmo_seen_q = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Snapshot on launch, load data on response, flush seen while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= '0;
      rdata_q      <= '0;
      flush_seen_q <= 1'b0;
    end else if ((state_q == IDLE) && (state_d == REQ)) begin
      req_q        <= req_new;
      rdata_q      <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      if (load_cap) rdata_q <= rdata_ext;
      if (((state_q == REQ) || (state_q == RESP)) && flush) flush_seen_q <= 1'b1;
    end
  end

  // Next state and all outputs; reset forces every output to zero.
  always_comb begin
    state_d           = state_q;
    load_cap          = 1'b0;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    dmem_addr         = '0;
    dmem_wdata        = '0;
    dmem_be           = '0;
    stall_out         = 1'b0;
    misalign_out      = 1'b0;
    regwrite_out      = 1'b0;
    mem_to_reg_out    = '0;
    mem_read_data_out = '0;
    alu_result_out    = '0;
    pc_plus_4_out     = '0;
    rd_out            = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          mem_to_reg_out = mem_to_reg_in;
          alu_result_out = alu_result_in;
          pc_plus_4_out  = pc_plus_4_in;
          rd_out         = rd_in;
          if (mem_op) begin
            if (misaligned) misalign_out = 1'b1;
            else begin
              stall_out = 1'b1;
              state_d   = REQ;
            end
          end else begin
            regwrite_out = regwrite_in & valid_in & ~flush;
          end
        end
        REQ, RESP: begin
          stall_out      = 1'b1;
          mem_to_reg_out = req_q.mem_to_reg;
          alu_result_out = req_q.alu_result;
          pc_plus_4_out  = req_q.pc_plus_4;
          rd_out         = req_q.rd;
          if (state_q == REQ) begin
            dmem_req   = 1'b1;
            dmem_we    = req_q.mem_write;
            dmem_addr  = {req_q.alu_result[ADDR_WIDTH-1:2], 2'b00};
            dmem_be    = req_q.be;
            dmem_wdata = req_q.wdata;
            if (dmem_ready) begin
              if (req_q.mem_write) state_d = DONE;
              else if (dmem_rvalid) begin
                load_cap = 1'b1;
                state_d  = DONE;
              end else state_d = RESP;
            end else if (tmo_hit) state_d = DONE;
          end else begin
            if (dmem_rvalid) begin
              load_cap = 1'b1;
              state_d  = DONE;
            end else if (tmo_hit) state_d = DONE;
          end
        end
        DONE: begin
          mem_to_reg_out    = req_q.mem_to_reg;
          alu_result_out    = req_q.alu_result;
          pc_plus_4_out     = req_q.pc_plus_4;
          rd_out            = req_q.rd;
          mem_read_data_out = req_q.mem_read ? rdata_q : 32'h0;
          regwrite_out      = req_q.regwrite & ~flush_seen_q & ~tmo_seen_q;
          misalign_out      = tmo_seen_q;
          state_d           = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stimulus pushes expected write-back
// records into a queue; a monitor pops one whenever the DUT completes an
// instruction (write-back, misalign pulse, or end of a stall).
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        reset, valid_in, flush, regwrite_in, mem_read_in, mem_write_in;
  logic [1:0]  mem_to_reg_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, rs2_data_in, pc_plus_4_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_out, misalign_out, regwrite_out;
  logic [1:0]  mem_to_reg_out;
  logic [31:0] mem_read_data_out, alu_result_out, pc_plus_4_out;
  logic [4:0]  rd_out;

  mem_stage_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
    .regwrite_in(regwrite_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .pc_plus_4_in(pc_plus_4_in), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .misalign_out(misalign_out),
    .regwrite_out(regwrite_out), .mem_to_reg_out(mem_to_reg_out),
    .mem_read_data_out(mem_read_data_out), .alu_result_out(alu_result_out),
    .pc_plus_4_out(pc_plus_4_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] alu;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic expect_wb(input logic rw, input logic mis, input logic [4:0] rd,
                           input logic [31:0] data, input logic [31:0] alu, input string nm);
    exp_t e;
    e.rw = rw; e.mis = mis; e.rd = rd; e.data = data; e.alu = alu; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic issue(input logic rw, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
    valid_in = 1'b1; regwrite_in = rw; mem_read_in = rd_en; mem_write_in = wr_en;
    funct3_in = f3; alu_result_in = alu; rs2_data_in = rs2; rd_in = rd;
    pc_plus_4_in = alu + 32'd4; mem_to_reg_in = rd_en ? 2'b01 : 2'b00;
  endtask

  task automatic bubble();
    valid_in = 1'b0; regwrite_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    funct3_in = 3'b000; alu_result_in = '0; rs2_data_in = '0; rd_in = '0;
    pc_plus_4_in = '0; mem_to_reg_in = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Monitor: one scoreboard record per completed instruction.
  initial begin : monitor
    logic prev_stall;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prev_stall = 1'b0;
      else begin
        if (regwrite_out || misalign_out || (prev_stall && !stall_out)) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_wb: rw=%0b mis=%0b rd=%0d data=0x%08h alu=0x%08h",
                     regwrite_out, misalign_out, rd_out, mem_read_data_out, alu_result_out);
          end else begin
            e = sb.pop_front();
            if (regwrite_out !== e.rw || misalign_out !== e.mis || rd_out !== e.rd ||
                mem_read_data_out !== e.data || alu_result_out !== e.alu) begin
              miscompares++;
              $display("FAIL wb_%s: got rw=%0b mis=%0b rd=%0d data=0x%08h alu=0x%08h expected rw=%0b mis=%0b rd=%0d data=0x%08h alu=0x%08h",
                       e.nm, regwrite_out, misalign_out, rd_out, mem_read_data_out, alu_result_out,
                       e.rw, e.mis, e.rd, e.data, e.alu);
            end
          end
        end
        prev_stall = stall_out;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; flush = 1'b0; bubble();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_rw", 32'(regwrite_out), 32'd0);
    check("rst_mis", 32'(misalign_out), 32'd0);
    next_cycle(); reset = 1'b0;

    // LH 0x6, bus answers ready+rvalid in the REQ cycle
    next_cycle();
    issue(1, 1, 0, 3'b001, 32'h6, 32'h0, 5'd5);
    expect_wb(1, 0, 5'd5, 32'hFFFF8765, 32'h6, "LH");
    @(negedge clk);
    check("lh_launch_stall", 32'(stall_out), 32'd1);
    check("lh_launch_req", 32'(dmem_req), 32'd0);
    check("lh_launch_rw", 32'(regwrite_out), 32'd0);
    next_cycle(); dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h87654321;
    @(negedge clk);
    check("lh_req", 32'(dmem_req), 32'd1);
    check("lh_addr", dmem_addr, 32'h4);
    check("lh_we", 32'(dmem_we), 32'd0);
    check("lh_req_stall", 32'(stall_out), 32'd1);
    next_cycle(); dmem_ready = 1'b0; dmem_rvalid = 1'b0; bubble();
    @(negedge clk);
    check("lh_done_stall", 32'(stall_out), 32'd0);
    check("lh_done_req", 32'(dmem_req), 32'd0);
    next_cycle();
    @(negedge clk);
    check("lh_rw_one_cycle", 32'(regwrite_out), 32'd0);

    // SB 0x3, bus holds off for 3 cycles; EX/MEM inputs scrambled meanwhile
    next_cycle();
    issue(0, 0, 1, 3'b000, 32'h3, 32'h000000AB, 5'd0);
    expect_wb(0, 0, 5'd0, 32'h0, 32'h3, "SB");
    @(negedge clk);
    check("sb_launch_stall", 32'(stall_out), 32'd1);
    next_cycle(); alu_result_in = 32'hDEADBEEF; rs2_data_in = 32'h0; funct3_in = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sb_req", 32'(dmem_req), 32'd1);
      check("sb_we", 32'(dmem_we), 32'd1);
      check("sb_be", 32'(dmem_be), 32'h8);
      check("sb_wdata", dmem_wdata, 32'hABABABAB);
      check("sb_addr", dmem_addr, 32'h0);
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("sb_req_accept", 32'(dmem_req), 32'd1);
    next_cycle(); dmem_ready = 1'b0; bubble();
    @(negedge clk);
    check("sb_done_stall", 32'(stall_out), 32'd0);

    // LW 0x2: misaligned, no bus access
    next_cycle();
    issue(1, 1, 0, 3'b010, 32'h2, 32'h0, 5'd7);
    expect_wb(0, 1, 5'd7, 32'h0, 32'h2, "LW_mis");
    @(negedge clk);
    check("lw_mis_pulse", 32'(misalign_out), 32'd1);
    check("lw_mis_req", 32'(dmem_req), 32'd0);
    check("lw_mis_stall", 32'(stall_out), 32'd0);
    next_cycle(); bubble();
    @(negedge clk);
    check("lw_mis_end", 32'(misalign_out), 32'd0);
    check("lw_mis_req2", 32'(dmem_req), 32'd0);

    // SUB pass-through
    next_cycle();
    issue(1, 0, 0, 3'b000, 32'hFFFFFFFF, 32'h0, 5'd6);
    expect_wb(1, 0, 5'd6, 32'h0, 32'hFFFFFFFF, "SUB");
    @(negedge clk);
    check("sub_stall", 32'(stall_out), 32'd0);
    check("sub_pc4", pc_plus_4_out, 32'h3);
    next_cycle(); bubble();

    // SH 0x12, zero-wait bus
    next_cycle();
    issue(0, 0, 1, 3'b001, 32'h12, 32'h00001234, 5'd0);
    expect_wb(0, 0, 5'd0, 32'h0, 32'h12, "SH");
    @(negedge clk);
    next_cycle(); dmem_ready = 1'b1;
    @(negedge clk);
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'h12341234);
    check("sh_addr", dmem_addr, 32'h10);
    next_cycle(); dmem_ready = 1'b0; bubble();
    @(negedge clk);

    // LB 0x20 through RESP, negative byte
    next_cycle();
    issue(1, 1, 0, 3'b000, 32'h20, 32'h0, 5'd8);
    expect_wb(1, 0, 5'd8, 32'hFFFFFF80, 32'h20, "LB");
    @(negedge clk);
    next_cycle(); dmem_ready = 1'b1;
    @(negedge clk);
    next_cycle(); dmem_ready = 1'b0;
    @(negedge clk);
    check("lb_resp_req", 32'(dmem_req), 32'd0);
    check("lb_resp_stall", 32'(stall_out), 32'd1);
    next_cycle(); dmem_rvalid = 1'b1; dmem_rdata = 32'h00000080;
    @(negedge clk);
    next_cycle(); dmem_rvalid = 1'b0; bubble();
    @(negedge clk);

    // LBU 0x1 with flush during RESP
    next_cycle();
    issue(1, 1, 0, 3'b100, 32'h1, 32'h0, 5'd9);
    expect_wb(0, 0, 5'd9, 32'h000000F0, 32'h1, "LBU_flush");
    @(negedge clk);
    next_cycle(); dmem_ready = 1'b1;
    @(negedge clk);
    next_cycle(); dmem_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("lbu_flush_stall", 32'(stall_out), 32'd1);
    check("lbu_flush_rw", 32'(regwrite_out), 32'd0);
    next_cycle(); flush = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000F000;
    @(negedge clk);
    next_cycle(); dmem_rvalid = 1'b0; bubble();
    @(negedge clk);

    // Stray rvalid while idle
    next_cycle(); dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("stray_req", 32'(dmem_req), 32'd0);
    check("stray_stall", 32'(stall_out), 32'd0);
    check("stray_data", mem_read_data_out, 32'h0);
    next_cycle(); dmem_rvalid = 1'b0;

    // Reset while in REQ
    next_cycle();
    issue(1, 1, 0, 3'b010, 32'h8, 32'h0, 5'd3);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("rstmid_req_before", 32'(dmem_req), 32'd1);
    #2; reset = 1'b1; bubble();
    @(negedge clk);
    check("rstmid_req", 32'(dmem_req), 32'd0);
    check("rstmid_stall", 32'(stall_out), 32'd0);
    check("rstmid_rw", 32'(regwrite_out), 32'd0);
    next_cycle(); reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    check("rstmid_late_req", 32'(dmem_req), 32'd0);
    check("rstmid_late_stall", 32'(stall_out), 32'd0);
    check("rstmid_late_rw", 32'(regwrite_out), 32'd0);
    next_cycle(); dmem_rvalid = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
